// File: rtl/rice_core_divider_if.sv
// Issue-side request and result-beat bundle for the iterative divide unit.
// The issue stage uses the master modport and the divider uses the slave modport.
interface rice_core_divider_if #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
);
    logic                 i_valid;
    logic                 o_ready;
    logic [1:0]           i_op;
    logic [XLEN-1:0]      i_rs1_value;
    logic [XLEN-1:0]      i_rs2_value;
    logic [RF_ADDR_W-1:0] i_rd;
    logic                 i_flush;
    logic                 o_valid;
    logic [RF_ADDR_W-1:0] o_rd;
    logic [XLEN-1:0]      o_rd_value;
    logic                 o_busy;

    modport master (
        output i_valid, i_op, i_rs1_value, i_rs2_value, i_rd, i_flush,
        input  o_ready, o_valid, o_rd, o_rd_value, o_busy
    );

    modport slave (
        input  i_valid, i_op, i_rs1_value, i_rs2_value, i_rd, i_flush,
        output o_ready, o_valid, o_rd, o_rd_value, o_busy
    );
endinterface

// File: rtl/rice_core_divider.sv
// Radix-2 restoring DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
// Optional RICE_CORE_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow jump straight to DONE.
//
// state | meaning
// IDLE  | waiting for a request, o_ready high unless flushing
// CALC  | XLEN iterations, counter XLEN-1 down to 0
// DONE  | result beat presented for one cycle
module rice_core_divider #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    rice_core_divider_if.slave     div_if
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [XLEN-1:0]      quo_q, rem_q, dsr_q, spec_res_q, res_q;
    logic [RF_ADDR_W-1:0] rd_q;
    logic                 is_rem_q, neg_quo_q, neg_rem_q, special_q;

    logic                 ready, busy, res_valid, accept;
    logic                 op_signed, op_rem, a_neg, b_neg;
    logic                 div_zero, overflow, special_in;
    logic [XLEN-1:0]      a_val, b_val, a_mag, b_mag, spec_val;
    logic [XLEN:0]        shifted, trial;
    logic                 fits;
    logic [XLEN-1:0]      quo_nx, rem_nx, quo_fin, rem_fin, calc_res;

    // Request decode
    always_comb begin
        a_val      = div_if.i_rs1_value;
        b_val      = div_if.i_rs2_value;
        op_signed  = ~div_if.i_op[0];
        op_rem     = div_if.i_op[1];
        a_neg      = op_signed & a_val[XLEN-1];
        b_neg      = op_signed & b_val[XLEN-1];
        a_mag      = a_neg ? -a_val : a_val;
        b_mag      = b_neg ? -b_val : b_val;
        div_zero   = (b_val == '0);
        overflow   = op_signed & (a_val == {1'b1, {(XLEN-1){1'b0}}}) & (b_val == '1);
        special_in = div_zero | overflow;
        if (div_zero) begin
            spec_val = op_rem ? a_val : '1;
        end else begin
            spec_val = op_rem ? '0 : a_val;
        end
    end

    assign accept = div_if.i_valid & ready;

    // One restoring step; the borrow bit of the trial subtraction decides the quotient bit
    always_comb begin
        shifted  = {rem_q, quo_q[XLEN-1]};
        trial    = shifted - {1'b0, dsr_q};
        fits     = ~trial[XLEN];
        rem_nx   = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        quo_nx   = {quo_q[XLEN-2:0], fits};
        quo_fin  = neg_quo_q ? -quo_nx : quo_nx;
        rem_fin  = neg_rem_q ? -rem_nx : rem_nx;
        calc_res = special_q ? spec_res_q : (is_rem_q ? rem_fin : quo_fin);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef RICE_CORE_DIV_EARLY_OUT_EN
                    state_d = special_in ? S_DONE : S_CALC;
`else
                    state_d = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (div_if.i_flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready     = 1'b0;
        busy      = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            S_IDLE: ready = ~div_if.i_flush;
            S_CALC: busy  = 1'b1;
            S_DONE: begin
                busy      = 1'b1;
                res_valid = ~div_if.i_flush;
            end
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dsr_q      <= '0;
            spec_res_q <= '0;
            res_q      <= '0;
            rd_q       <= '0;
            is_rem_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            special_q  <= 1'b0;
        end else if (accept) begin
            cnt_q      <= CNT_W'(XLEN - 1);
            quo_q      <= a_mag;
            rem_q      <= '0;
            dsr_q      <= b_mag;
            spec_res_q <= spec_val;
            rd_q       <= div_if.i_rd;
            is_rem_q   <= op_rem;
            neg_quo_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            special_q  <= special_in;
`ifdef RICE_CORE_DIV_EARLY_OUT_EN
            if (special_in) begin
                res_q <= spec_val;
            end
`endif
        end else if (state_q == S_CALC && !div_if.i_flush) begin
            cnt_q <= cnt_q - CNT_W'(1);
            quo_q <= quo_nx;
            rem_q <= rem_nx;
            if (cnt_q == '0) begin
                res_q <= calc_res;
            end
        end
    end

    assign div_if.o_ready    = ready;
    assign div_if.o_busy     = busy;
    assign div_if.o_valid    = res_valid;
    assign div_if.o_rd       = rd_q;
    assign div_if.o_rd_value = res_q;

endmodule

// File: tb/tb_rice_core_divider.sv
// Directed testbench for rice_core_divider (XLEN=32); special-case latency follows
// RICE_CORE_DIV_EARLY_OUT_EN when it is defined for the build.
module tb_rice_core_divider;
    localparam int XLEN     = 32;
    localparam int RF_W     = 5;
    localparam int FULL_LAT = 33;
`ifdef RICE_CORE_DIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 33;
`endif

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef struct packed {
        logic [1:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [RF_W-1:0] rd;
        logic [XLEN-1:0] exp;
    } vec_t;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 i_clk = ~i_clk;

    rice_core_divider_if #(.XLEN(XLEN), .RF_ADDR_W(RF_W)) dif ();

    rice_core_divider #(.XLEN(XLEN), .RF_ADDR_W(RF_W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .div_if  (dif)
    );

    // Drives one request, then observes the result beats over a bounded window
    task automatic issue_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [RF_W-1:0] rd, input int window,
                            output logic rdy, output int nval, output int lat,
                            output logic [RF_W-1:0] grd, output logic [XLEN-1:0] gval);
        @(negedge i_clk);
        rdy              = dif.o_ready;
        dif.i_valid      = 1'b1;
        dif.i_op         = op;
        dif.i_rs1_value  = a;
        dif.i_rs2_value  = b;
        dif.i_rd         = rd;
        @(posedge i_clk);
        #1;
        dif.i_valid = 1'b0;
        nval = 0;
        lat  = -1;
        grd  = '0;
        gval = '0;
        for (int k = 1; k <= window; k++) begin
            @(negedge i_clk);
            if (dif.o_valid === 1'b1) begin
                nval++;
                if (lat < 0) begin
                    lat  = k;
                    grd  = dif.o_rd;
                    gval = dif.o_rd_value;
                end
            end
        end
    endtask

    task automatic test_reset();
        dif.i_valid     = 1'b0;
        dif.i_op        = 2'b00;
        dif.i_rs1_value = '0;
        dif.i_rs2_value = '0;
        dif.i_rd        = '0;
        dif.i_flush     = 1'b0;
        i_rst_n         = 1'b0;
        #12;
        checks++; if (dif.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", dif.o_valid); end
        checks++; if (dif.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", dif.o_ready); end
        checks++; if (dif.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", dif.o_busy); end
        checks++; if (dif.o_rd !== '0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", dif.o_rd); end
        checks++; if (dif.o_rd_value !== '0) begin errors++; $display("FAIL reset_value got=%h exp=0", dif.o_rd_value); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checks++; if (dif.o_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b exp=1", dif.o_ready); end
    endtask

    task automatic run_table(input string tag, input vec_t v, input int idx, input int exp_lat);
        logic rdy; int nval; int lat; logic [RF_W-1:0] grd; logic [XLEN-1:0] gval;
        issue_op(v.op, v.a, v.b, v.rd, exp_lat + 3, rdy, nval, lat, grd, gval);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL %s[%0d] ready got=%b exp=1", tag, idx, rdy); end
        checks++; if (nval != 1) begin errors++; $display("FAIL %s[%0d] beats got=%0d exp=1", tag, idx, nval); end
        checks++; if (lat != exp_lat) begin errors++; $display("FAIL %s[%0d] latency got=%0d exp=%0d", tag, idx, lat, exp_lat); end
        checks++; if (grd !== v.rd) begin errors++; $display("FAIL %s[%0d] rd got=%0d exp=%0d", tag, idx, grd, v.rd); end
        checks++; if (gval !== v.exp) begin errors++; $display("FAIL %s[%0d] value got=%h exp=%h", tag, idx, gval, v.exp); end
    endtask

    task automatic test_unsigned();
        vec_t v[5];
        v[0] = '{OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14};
        v[1] = '{OP_REMU, 32'd100, 32'd7, 5'd5, 32'd2};
        v[2] = '{OP_DIVU, 32'hFFFF_FFFF, 32'h10, 5'd0, 32'h0FFF_FFFF};
        v[3] = '{OP_REMU, 32'hFFFF_FFFF, 32'h10, 5'd31, 32'hF};
        v[4] = '{OP_DIVU, 32'd3, 32'd5, 5'd12, 32'd0};
        for (int i = 0; i < 5; i++) run_table("unsigned", v[i], i, FULL_LAT);
    endtask

    task automatic test_signed();
        vec_t v[6];
        v[0] = '{OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD};
        v[1] = '{OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF};
        v[2] = '{OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd3, 32'hFFFF_FFFD};
        v[3] = '{OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'd1};
        v[4] = '{OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd8, 32'd3};
        v[5] = '{OP_REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd9, 32'hFFFF_FFFF};
        for (int i = 0; i < 6; i++) run_table("signed", v[i], i, FULL_LAT);
    endtask

    task automatic test_special();
        vec_t v[6];
        v[0] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h8000_0000};
        v[1] = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h0};
        v[2] = '{OP_DIVU, 32'd5, 32'd0, 5'd3, 32'hFFFF_FFFF};
        v[3] = '{OP_REMU, 32'd5, 32'd0, 5'd4, 32'd5};
        v[4] = '{OP_DIV,  32'hFFFF_FFFB, 32'd0, 5'd6, 32'hFFFF_FFFF};
        v[5] = '{OP_REM,  32'hFFFF_FFFB, 32'd0, 5'd7, 32'hFFFF_FFFB};
        for (int i = 0; i < 6; i++) run_table("special", v[i], i, SPEC_LAT);
    endtask

    task automatic test_flush();
        int seen;
        logic rdy; int nval; int lat; logic [RF_W-1:0] grd; logic [XLEN-1:0] gval;
        // Flush together with a request in IDLE must block acceptance
        @(negedge i_clk);
        dif.i_valid = 1'b1; dif.i_op = OP_DIVU; dif.i_rs1_value = 32'd50; dif.i_rs2_value = 32'd5; dif.i_rd = 5'd2;
        dif.i_flush = 1'b1;
        #1;
        checks++; if (dif.o_ready !== 1'b0) begin errors++; $display("FAIL flush_idle_ready got=%b exp=0", dif.o_ready); end
        @(posedge i_clk);
        #1;
        dif.i_valid = 1'b0; dif.i_flush = 1'b0;
        @(negedge i_clk);
        checks++; if (dif.o_busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got=%b exp=0", dif.o_busy); end

        // Flush at CALC cycle 10
        @(negedge i_clk);
        dif.i_valid = 1'b1; dif.i_op = OP_DIVU; dif.i_rs1_value = 32'd100; dif.i_rs2_value = 32'd7; dif.i_rd = 5'd3;
        @(posedge i_clk);
        #1;
        dif.i_valid = 1'b0;
        seen = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge i_clk);
            if (dif.o_valid === 1'b1) seen++;
        end
        checks++; if (dif.o_busy !== 1'b1) begin errors++; $display("FAIL flush_calc_busy got=%b exp=1", dif.o_busy); end
        dif.i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        dif.i_flush = 1'b0;
        @(negedge i_clk);
        checks++; if (dif.o_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_next got=%b exp=1", dif.o_ready); end
        checks++; if (dif.o_busy !== 1'b0) begin errors++; $display("FAIL flush_busy_next got=%b exp=0", dif.o_busy); end
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (dif.o_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_beat got=%0d beats exp=0", seen); end

        issue_op(OP_DIVU, 32'd9, 32'd3, 5'd4, FULL_LAT + 3, rdy, nval, lat, grd, gval);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL flush_after ready got=%b exp=1", rdy); end
        checks++; if (nval != 1) begin errors++; $display("FAIL flush_after beats got=%0d exp=1", nval); end
        checks++; if (lat != FULL_LAT) begin errors++; $display("FAIL flush_after latency got=%0d exp=%0d", lat, FULL_LAT); end
        checks++; if (grd !== 5'd4) begin errors++; $display("FAIL flush_after rd got=%0d exp=4", grd); end
        checks++; if (gval !== 32'd3) begin errors++; $display("FAIL flush_after value got=%h exp=3", gval); end
    endtask

    task automatic test_back_to_back();
        int b_acc, nv;
        int vk[2];
        logic [RF_W-1:0] vrd[2];
        logic [XLEN-1:0] vval[2];
        vk[0] = -1; vk[1] = -1; vrd[0] = '0; vrd[1] = '0; vval[0] = '0; vval[1] = '0;
        @(negedge i_clk);
        checks++; if (dif.o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got=%b exp=1", dif.o_ready); end
        dif.i_valid = 1'b1; dif.i_op = OP_DIVU; dif.i_rs1_value = 32'd100; dif.i_rs2_value = 32'd7; dif.i_rd = 5'd5;
        @(posedge i_clk);
        #1;
        dif.i_op = OP_REMU; dif.i_rd = 5'd6;
        b_acc = -1;
        nv = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge i_clk);
            if (dif.o_valid === 1'b1) begin
                if (nv < 2) begin
                    vk[nv] = k; vrd[nv] = dif.o_rd; vval[nv] = dif.o_rd_value;
                end
                nv++;
            end
            if (b_acc < 0 && dif.o_ready === 1'b1) begin
                b_acc = k;
                @(posedge i_clk);
                #1;
                dif.i_valid = 1'b0;
            end
        end
        dif.i_valid = 1'b0;
        checks++; if (b_acc != FULL_LAT + 1) begin errors++; $display("FAIL b2b_second_accept got=%0d exp=%0d", b_acc, FULL_LAT + 1); end
        checks++; if (nv != 2) begin errors++; $display("FAIL b2b_beats got=%0d exp=2", nv); end
        checks++; if (vk[0] != FULL_LAT) begin errors++; $display("FAIL b2b_lat0 got=%0d exp=%0d", vk[0], FULL_LAT); end
        checks++; if (vrd[0] !== 5'd5) begin errors++; $display("FAIL b2b_rd0 got=%0d exp=5", vrd[0]); end
        checks++; if (vval[0] !== 32'd14) begin errors++; $display("FAIL b2b_val0 got=%h exp=e", vval[0]); end
        checks++; if (vk[1] != 2 * FULL_LAT + 1) begin errors++; $display("FAIL b2b_lat1 got=%0d exp=%0d", vk[1], 2 * FULL_LAT + 1); end
        checks++; if (vrd[1] !== 5'd6) begin errors++; $display("FAIL b2b_rd1 got=%0d exp=6", vrd[1]); end
        checks++; if (vval[1] !== 32'd2) begin errors++; $display("FAIL b2b_val1 got=%h exp=2", vval[1]); end
    endtask

    task automatic test_reset_mid();
        int seen;
        logic rdy; int nval; int lat; logic [RF_W-1:0] grd; logic [XLEN-1:0] gval;
        @(negedge i_clk);
        dif.i_valid = 1'b1; dif.i_op = OP_DIVU; dif.i_rs1_value = 32'd1000; dif.i_rs2_value = 32'd10; dif.i_rd = 5'd7;
        @(posedge i_clk);
        #1;
        dif.i_valid = 1'b0;
        repeat (5) @(negedge i_clk);
        checks++; if (dif.o_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got=%b exp=1", dif.o_busy); end
        i_rst_n = 1'b0;
        #1;
        checks++; if (dif.o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", dif.o_valid); end
        checks++; if (dif.o_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", dif.o_ready); end
        checks++; if (dif.o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", dif.o_busy); end
        checks++; if (dif.o_rd !== '0) begin errors++; $display("FAIL rstmid_rd got=%0d exp=0", dif.o_rd); end
        checks++; if (dif.o_rd_value !== '0) begin errors++; $display("FAIL rstmid_value got=%h exp=0", dif.o_rd_value); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (dif.o_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_beat got=%0d beats exp=0", seen); end
        issue_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd9, FULL_LAT + 3, rdy, nval, lat, grd, gval);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rstmid_after ready got=%b exp=1", rdy); end
        checks++; if (nval != 1) begin errors++; $display("FAIL rstmid_after beats got=%0d exp=1", nval); end
        checks++; if (lat != FULL_LAT) begin errors++; $display("FAIL rstmid_after latency got=%0d exp=%0d", lat, FULL_LAT); end
        checks++; if (grd !== 5'd9) begin errors++; $display("FAIL rstmid_after rd got=%0d exp=9", grd); end
        checks++; if (gval !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rstmid_after value got=%h exp=ffffffff", gval); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
